pkt_sync_recv: RTL and testbench

PKT_SYNC_RECV -- requirements
Module: pkt_sync_recv

---
 rtl/pkt_pkg.sv | 28 ++
 rtl/sdp_ram_134.sv | 32 +++
 rtl/pkt_sync_recv.sv | 226 ++++++++++++++++++++++
 tb/tb_pkt_sync_recv.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet store-and-forward receiver: word layout,
// tag encodings and the write-side FSM state type.
package pkt_pkg;

  localparam int unsigned WORD_W    = 134;
  localparam int unsigned PAYLOAD_W = 128;
  localparam int unsigned TAG_HI    = 133;
  localparam int unsigned TAG_LO    = 132;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_HEAD = 2'b01;
  localparam tag_t TAG_BODY = 2'b11;
  localparam tag_t TAG_TAIL = 2'b10;

  typedef struct packed {
    tag_t                 tag;
    logic [3:0]           rsvd;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_word_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sdp_ram_134.sv
// Simple dual-port packet buffer: one write port, one read port with a
// single-cycle registered read.
module sdp_ram_134
  import pkt_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pkt_sync_recv.sv
// Store-and-forward packet receiver: packets are written speculatively and only
// become readable once their tail commits; malformed or oversize packets roll back.
module pkt_sync_recv
  import pkt_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned MAX_PKT = 128
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_data_valid,
  output logic [WORD_W-1:0] o_data,
  input  logic              i_ready,
  output logic [15:0]       o_drop_cnt,
  output logic [15:0]       o_pkt_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  wr_state_e         state_q, state_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              start_q, start_d;
  ptr_t              commit_q, commit_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              rel_ptr_q, rel_ptr_d;
  ptr_t              cnt_q, cnt_d;
  logic [15:0]       drop_q, drop_d;
  logic [15:0]       pkt_q, pkt_d;
  logic              out_v_q, out_v_d;
  logic              skid_v_q, skid_v_d;
  logic              infl_q;
  pkt_word_t         out_q, out_d;
  pkt_word_t         skid_q, skid_d;

  tag_t              tag_in;
  logic              is_head, is_body, is_tail;
  logic              wr_en_c;
  logic [AW-1:0]     wr_addr_c;
  logic              head_go_c;
  ptr_t              head_base_c;
  ptr_t              used_c;
  ptr_t              free_c;
  logic [1:0]        drop_inc_c;
  logic [16:0]       drop_sum_c;
  logic              pop_c;
  logic [2:0]        occ_c;
  logic              issue_c;
  logic [WORD_W-1:0] rd_data_w;

  assign tag_in  = i_data[TAG_HI:TAG_LO];
  assign is_head = i_data_valid && (tag_in == TAG_HEAD);
  assign is_body = i_data_valid && (tag_in == TAG_BODY);
  assign is_tail = i_data_valid && (tag_in == TAG_TAIL);

  // Write FSM state register
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q <= WR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write-side next state; a head in any state is resolved after the case so
  // that a rollback and the new-head admission share one cycle.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_d     = start_q;
    commit_d    = commit_q;
    cnt_d       = cnt_q;
    wr_en_c     = 1'b0;
    wr_addr_c   = wr_ptr_q[AW-1:0];
    head_go_c   = 1'b0;
    head_base_c = wr_ptr_q;
    drop_inc_c  = 2'd0;

    case (state_q)
      WR_IDLE: begin
        if (is_head) begin
          head_go_c = 1'b1;
        end else if (is_tail) begin
          drop_inc_c = 2'd1;
        end
      end
      WR_RECV: begin
        if (is_head) begin
          head_go_c   = 1'b1;
          head_base_c = start_q;
          wr_ptr_d    = start_q;
          drop_inc_c  = 2'd1;
        end else if (is_body || is_tail) begin
          if (cnt_q >= PW'(MAX_PKT)) begin
            wr_ptr_d   = start_q;
            drop_inc_c = 2'd1;
            state_d    = is_tail ? WR_IDLE : WR_DROP;
          end else begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            cnt_d    = cnt_q + PW'(1);
            if (is_tail) begin
              commit_d = wr_ptr_q + PW'(1);
              state_d  = WR_IDLE;
            end
          end
        end
      end
      WR_DROP: begin
        if (is_head) begin
          head_go_c = 1'b1;
        end else if (is_tail) begin
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase

    // Space is measured against words not yet handed to the consumer
    used_c = head_base_c - rel_ptr_q;
    free_c = PW'(DEPTH) - used_c;
    if (head_go_c) begin
      if (free_c >= PW'(MAX_PKT)) begin
        wr_en_c   = 1'b1;
        wr_addr_c = head_base_c[AW-1:0];
        wr_ptr_d  = head_base_c + PW'(1);
        start_d   = head_base_c;
        cnt_d     = PW'(1);
        state_d   = WR_RECV;
      end else begin
        drop_inc_c = drop_inc_c + 2'd1;
        state_d    = WR_DROP;
      end
    end

    drop_sum_c = {1'b0, drop_q} + 17'(drop_inc_c);
    drop_d     = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
  end

  // Read side: RAM fetch is issued only when the output and skid slots can absorb it
  always_comb begin
    pop_c     = out_v_q && i_ready;
    occ_c     = 3'(out_v_q) + 3'(skid_v_q) + 3'(infl_q) - 3'(pop_c);
    issue_c   = (commit_q != rd_ptr_q) && (occ_c < 3'd2);
    rd_ptr_d  = issue_c ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    rel_ptr_d = pop_c ? (rel_ptr_q + PW'(1)) : rel_ptr_q;
    pkt_d     = (pop_c && (out_q.tag == TAG_TAIL)) ? (pkt_q + 16'd1) : pkt_q;

    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (!out_v_q || pop_c) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = infl_q;
        skid_d   = pkt_word_t'(rd_data_w);
      end else begin
        out_v_d = infl_q;
        if (infl_q) begin
          out_d = pkt_word_t'(rd_data_w);
        end
      end
    end else if (infl_q) begin
      skid_v_d = 1'b1;
      skid_d   = pkt_word_t'(rd_data_w);
    end
  end

  // Pointers, counters and output stage
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      start_q   <= '0;
      commit_q  <= '0;
      rd_ptr_q  <= '0;
      rel_ptr_q <= '0;
      cnt_q     <= '0;
      drop_q    <= '0;
      pkt_q     <= '0;
      out_v_q   <= 1'b0;
      skid_v_q  <= 1'b0;
      infl_q    <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      start_q   <= start_d;
      commit_q  <= commit_d;
      rd_ptr_q  <= rd_ptr_d;
      rel_ptr_q <= rel_ptr_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      pkt_q     <= pkt_d;
      out_v_q   <= out_v_d;
      skid_v_q  <= skid_v_d;
      infl_q    <= issue_c;
      out_q     <= out_d;
      skid_q    <= skid_d;
    end
  end

  sdp_ram_134 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (i_sys_clk),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (i_data),
    .rd_en_i   (issue_c),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data_w)
  );

  assign o_data_valid = out_v_q;
  assign o_data       = out_q;
  assign o_drop_cnt   = drop_q;
  assign o_pkt_cnt    = pkt_q;

endmodule

// File: tb/tb_pkt_sync_recv.sv
// Bench for pkt_sync_recv: scenario tasks drive packets while a queue-based
// packet model predicts delivered words and counter values.
module tb_pkt_sync_recv;
  import pkt_pkg::*;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned MAX_PKT = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              dv;
  logic [WORD_W-1:0] din;
  logic              ov;
  logic [WORD_W-1:0] dout;
  logic              rdy;
  logic [15:0]       dropc;
  logic [15:0]       pktc;

  always #5 clk = ~clk;

  pkt_sync_recv #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
    .i_sys_clk    (clk),
    .i_rst        (rst),
    .i_data_valid (dv),
    .i_data       (din),
    .o_data_valid (ov),
    .o_data       (dout),
    .i_ready      (rdy),
    .o_drop_cnt   (dropc),
    .o_pkt_cnt    (pktc)
  );

  int checks   = 0;
  int failures = 0;

  // Packet model: committed words awaiting delivery plus the packet in progress
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] cur_q[$];
  bit                m_in_pkt;
  bit                m_discard;
  int                exp_drop;
  int                exp_pkt;
  int                delivered;
  int                seq_n;
  int                ready_mode;
  bit                prev_stall;
  logic [WORD_W-1:0] prev_data;
  logic [WORD_W-1:0] mon_w;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input tag_t t, input int s);
    return {t, 4'h0, 32'(s), $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    cur_q.delete();
    m_in_pkt  = 1'b0;
    m_discard = 1'b0;
    exp_drop  = 0;
    exp_pkt   = 0;
    delivered = 0;
  endtask

  task automatic model_word(input logic [WORD_W-1:0] w);
    tag_t t;
    t = w[TAG_HI:TAG_LO];
    if (t == TAG_HEAD) begin
      if (m_in_pkt) begin
        exp_drop++;
        cur_q.delete();
        m_in_pkt = 1'b0;
      end
      m_discard = 1'b0;
      if (int'(DEPTH) - (exp_q.size() + cur_q.size()) >= int'(MAX_PKT)) begin
        cur_q.push_back(w);
        m_in_pkt = 1'b1;
      end else begin
        exp_drop++;
        m_discard = 1'b1;
      end
    end else if (t == TAG_BODY || t == TAG_TAIL) begin
      if (m_in_pkt) begin
        if (cur_q.size() == int'(MAX_PKT)) begin
          exp_drop++;
          cur_q.delete();
          m_in_pkt  = 1'b0;
          m_discard = (t == TAG_BODY);
        end else begin
          cur_q.push_back(w);
          if (t == TAG_TAIL) begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            cur_q.delete();
            exp_pkt++;
            m_in_pkt = 1'b0;
          end
        end
      end else if (m_discard) begin
        if (t == TAG_TAIL) m_discard = 1'b0;
      end else if (t == TAG_TAIL) begin
        exp_drop++;
      end
    end
  endtask

  task automatic drive_word(input tag_t t);
    logic [WORD_W-1:0] w;
    @(posedge clk);
    #1;
    seq_n++;
    w   = mk_word(t, seq_n);
    dv  = 1'b1;
    din = w;
    model_word(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      dv = 1'b0;
    end
  endtask

  task automatic send_pkt(input int len, input bit with_tail);
    drive_word(TAG_HEAD);
    for (int i = 1; i < len - 1; i++) drive_word(TAG_BODY);
    drive_word(with_tail ? TAG_TAIL : TAG_BODY);
  endtask

  task automatic apply_reset(input bit with_word);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dv  = with_word;
    din = mk_word(TAG_TAIL, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dv  = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    idle(1);
    ready_mode = 1;
    for (int n = 0; n < 5000; n++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Consumer-side ready pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = ~rdy;
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: every accepted word must be the next expected one; stalls must hold
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || dout !== prev_data) begin
          failures++;
          $display("FAIL stall_hold: got valid=%0b data=%h, required valid=1 data=%h", ov, dout, prev_data);
        end
      end
      if (ov === 1'b1 && rdy === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %h, required no word", dout);
        end else begin
          mon_w = exp_q.pop_front();
          if (dout !== mon_w) begin
            failures++;
            $display("FAIL out_word: got %h, required %h", dout, mon_w);
          end
        end
        delivered++;
      end
      prev_stall = (ov === 1'b1) && (rdy !== 1'b1);
      prev_data  = dout;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    dv  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (ov !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", ov); end
    if (dout !== '0) begin failures++; $display("FAIL rst_data: got %h, required 0", dout); end
    if (dropc !== 16'd0) begin failures++; $display("FAIL rst_drop: got %0d, required 0", dropc); end
    if (pktc !== 16'd0) begin failures++; $display("FAIL rst_pkt: got %0d, required 0", pktc); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    apply_reset(1'b0);
    ready_mode = 1;
    idle(1);
    drive_word(TAG_HEAD);
    drive_word(TAG_BODY);
    drive_word(TAG_BODY);
    drive_word(TAG_TAIL);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      dv = 1'b0;
      lat++;
      if (ov === 1'b1) break;
    end
    checks++;
    if (lat < 2 || lat > 3) begin failures++; $display("FAIL basic_latency: got %0d cycles, required 2..3", lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ov !== 1'b1) begin failures++; $display("FAIL basic_stream: word %0d valid=%b, required 1", i, ov); end
    end
    wait_drain(ok);
    checks += 5;
    if (!ok) begin failures++; $display("FAIL basic_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 4) begin failures++; $display("FAIL basic_count: got %0d words, required 4", delivered); end
    if (pktc !== 16'd1) begin failures++; $display("FAIL basic_pkt: got %0d, required 1", pktc); end
    if (dropc !== 16'd0) begin failures++; $display("FAIL basic_drop: got %0d, required 0", dropc); end
    if (ov !== 1'b0) begin failures++; $display("FAIL basic_idle: got valid=%b, required 0", ov); end
  endtask

  task automatic test_missing_tail();
    bit ok;
    apply_reset(1'b0);
    ready_mode = 1;
    drive_word(TAG_HEAD);
    drive_word(TAG_BODY);
    drive_word(TAG_BODY);
    send_pkt(3, 1'b1);
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL mt_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 3) begin failures++; $display("FAIL mt_count: got %0d words, required 3", delivered); end
    if (pktc !== 16'd1) begin failures++; $display("FAIL mt_pkt: got %0d, required 1", pktc); end
    if (dropc !== 16'd1) begin failures++; $display("FAIL mt_drop: got %0d, required 1", dropc); end
  endtask

  task automatic test_full();
    bit ok;
    apply_reset(1'b0);
    ready_mode = 0;
    send_pkt(128, 1'b1);
    send_pkt(128, 1'b1);
    send_pkt(127, 1'b1);
    send_pkt(2, 1'b1);
    send_pkt(4, 1'b1);
    idle(3);
    checks += 2;
    if (dropc !== 16'd1) begin failures++; $display("FAIL full_drop: got %0d, required 1", dropc); end
    if (ov !== 1'b1) begin failures++; $display("FAIL full_present: got valid=%b, required 1", ov); end
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL full_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 385) begin failures++; $display("FAIL full_count: got %0d words, required 385", delivered); end
    if (pktc !== 16'd4) begin failures++; $display("FAIL full_pkt: got %0d, required 4", pktc); end
    if (dropc !== 16'd1) begin failures++; $display("FAIL full_drop2: got %0d, required 1", dropc); end
    // Exactly MAX_PKT free words must still admit a packet, across pointer wrap
    ready_mode = 0;
    send_pkt(128, 1'b1);
    send_pkt(128, 1'b1);
    send_pkt(128, 1'b1);
    send_pkt(2, 1'b1);
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL edge_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 771) begin failures++; $display("FAIL edge_count: got %0d words, required 771", delivered); end
    if (pktc !== 16'd8) begin failures++; $display("FAIL edge_pkt: got %0d, required 8", pktc); end
    if (dropc !== 16'd1) begin failures++; $display("FAIL edge_drop: got %0d, required 1", dropc); end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset(1'b0);
    ready_mode = 1;
    send_pkt(130, 1'b1);
    send_pkt(3, 1'b1);
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL ovf_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 3) begin failures++; $display("FAIL ovf_count: got %0d words, required 3", delivered); end
    if (pktc !== 16'd1) begin failures++; $display("FAIL ovf_pkt: got %0d, required 1", pktc); end
    if (dropc !== 16'd1) begin failures++; $display("FAIL ovf_drop: got %0d, required 1", dropc); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset(1'b0);
    ready_mode = 2;
    for (int i = 0; i < 24; i++) send_pkt(2, 1'b1);
    idle(1);
    ready_mode = 2;
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL b2b_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 48) begin failures++; $display("FAIL b2b_count: got %0d words, required 48", delivered); end
    if (pktc !== 16'd24) begin failures++; $display("FAIL b2b_pkt: got %0d, required 24", pktc); end
    if (dropc !== 16'd0) begin failures++; $display("FAIL b2b_drop: got %0d, required 0", dropc); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset(1'b0);
    ready_mode = 0;
    send_pkt(2, 1'b1);
    idle(4);
    checks++;
    if (ov !== 1'b1) begin failures++; $display("FAIL rm_pre_valid: got %b, required 1", ov); end
    drive_word(TAG_HEAD);
    drive_word(TAG_BODY);
    drive_word(TAG_BODY);
    apply_reset(1'b1);
    checks += 3;
    if (ov !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b, required 0", ov); end
    if (dropc !== 16'd0) begin failures++; $display("FAIL rm_drop0: got %0d, required 0", dropc); end
    if (pktc !== 16'd0) begin failures++; $display("FAIL rm_pkt0: got %0d, required 0", pktc); end
    ready_mode = 1;
    send_pkt(3, 1'b1);
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL rm_drain: %0d words left, required 0", exp_q.size()); end
    if (delivered != 3) begin failures++; $display("FAIL rm_count: got %0d words, required 3", delivered); end
    if (pktc !== 16'd1) begin failures++; $display("FAIL rm_pkt: got %0d, required 1", pktc); end
    if (dropc !== 16'd0) begin failures++; $display("FAIL rm_drop: got %0d, required 0", dropc); end
  endtask

  task automatic test_random();
    bit ok;
    int r;
    apply_reset(1'b0);
    ready_mode = 3;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      drive_word(TAG_TAIL);
      else if (r == 1) drive_word(TAG_BODY);
      else if (r == 2) send_pkt($urandom_range(2, 6), 1'b0);
      else if (r == 3) send_pkt($urandom_range(MAX_PKT - 1, MAX_PKT + 2), 1'b1);
      else             send_pkt($urandom_range(2, 10), 1'b1);
      idle($urandom_range(0, 2));
    end
    wait_drain(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL rnd_drain: %0d words left, required 0", exp_q.size()); end
    if (pktc !== 16'(exp_pkt)) begin failures++; $display("FAIL rnd_pkt: got %0d, required %0d", pktc, exp_pkt); end
    if (dropc !== sat16(exp_drop)) begin failures++; $display("FAIL rnd_drop: got %0d, required %0d", dropc, exp_drop); end
    if (ov !== 1'b0) begin failures++; $display("FAIL rnd_idle: got valid=%b, required 0", ov); end
  endtask

  initial begin
    rst        = 1'b1;
    dv         = 1'b0;
    din        = '0;
    rdy        = 1'b0;
    ready_mode = 0;
    seq_n      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    model_clear();
    test_reset();
    test_basic();
    test_missing_tail();
    test_full();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
